// File: rtl/spi_master_bridge.sv
// Purpose: SPI mode-0 initiator issuing one 24-bit register read/write frame per request.
// Latency: ncs low CS_SETUP + 48*CLK_DIV + CS_HOLD cycles; rsp_valid_o on the first ncs-high cycle.
// Backpressure: req_ready_o high only in IDLE; requests presented while busy wait unconsumed.
module spi_master_bridge #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  output logic       spi_ncs_o,
  input  logic       spi_miso_i
);

  // One down-counter serves setup, half-period, hold and gap timing, so it is
  // sized for the largest of the three reload values.
  localparam int CMAX = (CLK_DIV > CS_SETUP) ?
                        ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                        ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] DIV_RLD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_RLD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_RLD  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [4:0]    bit_q, bit_n;
  logic [23:0]   shreg_q, shreg_n;
  logic          sck_q, sck_n;
  logic          mosi_q, mosi_n;
  logic          ncs_q, ncs_n;
  logic          ready_q, ready_n;
  logic          busy_q, busy_n;
  logic          rsp_vld_q, rsp_vld_n;
  logic [7:0]    rsp_dat_q, rsp_dat_n;
  logic [23:0]   req_frame;

  // Read frames send zero in the data byte so req_data_i has no effect on them.
  assign req_frame = {(req_write_i ? 8'h80 : 8'h00), req_addr_i,
                      (req_write_i ? req_data_i : 8'h00)};

  // Register every state element and output; reset drops any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 8'h00;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bit_q     <= bit_n;
      shreg_q   <= shreg_n;
      sck_q     <= sck_n;
      mosi_q    <= mosi_n;
      ncs_q     <= ncs_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      rsp_vld_q <= rsp_vld_n;
      rsp_dat_q <= rsp_dat_n;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    bit_n     = bit_q;
    shreg_n   = shreg_q;
    sck_n     = sck_q;
    mosi_n    = mosi_q;
    ncs_n     = ncs_q;
    ready_n   = ready_q;
    busy_n    = busy_q;
    rsp_vld_n = 1'b0;
    rsp_dat_n = rsp_dat_q;

    case (state_q)
      ST_IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        sck_n   = 1'b0;
        ncs_n   = 1'b1;
        // ready_q gates the accept so the cycle straight after reset never consumes.
        if (req_valid_i && ready_q) begin
          state_n = ST_SETUP;
          cnt_n   = SETUP_RLD;
          shreg_n = req_frame;
          mosi_n  = req_frame[23];
          ncs_n   = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_n = ST_SHIFT;
          cnt_n   = DIV_RLD;
          bit_n   = 5'd23;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else if (!sck_q) begin
          // End of low phase: raise SCK, MOSI already stable.
          sck_n = 1'b1;
          cnt_n = DIV_RLD;
        end else begin
          // End of high phase: sample MISO, drop SCK, present next MOSI bit.
          sck_n   = 1'b0;
          shreg_n = {shreg_q[22:0], spi_miso_i};
          if (bit_q == 5'd0) begin
            state_n = ST_HOLD;
            cnt_n   = HOLD_RLD;
          end else begin
            bit_n  = bit_q - 5'd1;
            mosi_n = shreg_q[22];
            cnt_n  = DIV_RLD;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_n   = ST_GAP;
          cnt_n     = DIV_RLD;
          ncs_n     = 1'b1;
          mosi_n    = 1'b0;
          rsp_vld_n = 1'b1;
          rsp_dat_n = shreg_q[7:0];
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        ncs_n   = 1'b1;
        sck_n   = 1'b0;
      end
    endcase
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_data_o  = rsp_dat_q;
  assign busy_o      = busy_q;
  assign spi_clk_o   = sck_q;
  assign spi_mosi_o  = mosi_q;
  assign spi_ncs_o   = ncs_q;

endmodule

// File: tb/tb_spi_master_bridge.sv
// Bench for spi_master_bridge: default-parameter instance plus a CLK_DIV=2/1/1 instance.
// Stimulus issues directed requests; a target model drives MISO per frame.
// A negedge monitor tracks the SPI lines and checks each response against the queue.
module tb_spi_master_bridge;

  localparam int NCS_A = 196;  // 2 + 48*4 + 2
  localparam int NCS_B = 98;   // 1 + 48*2 + 1
  localparam int PER_A = 8;
  localparam int PER_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_valid, req_write, sel, miso;
  logic [7:0] req_addr, req_data;

  logic       a_ready, a_rsp_valid, a_busy, a_sck, a_mosi, a_ncs;
  logic       b_ready, b_rsp_valid, b_busy, b_sck, b_mosi, b_ncs;
  logic [7:0] a_rsp_data, b_rsp_data;

  spi_master_bridge dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & ~sel), .req_ready_o(a_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data), .busy_o(a_busy),
    .spi_clk_o(a_sck), .spi_mosi_o(a_mosi), .spi_ncs_o(a_ncs), .spi_miso_i(miso)
  );

  spi_master_bridge #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & sel), .req_ready_o(b_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .busy_o(b_busy),
    .spi_clk_o(b_sck), .spi_mosi_o(b_mosi), .spi_ncs_o(b_ncs), .spi_miso_i(miso)
  );

  // Observed view of whichever instance is under test.
  logic       ready, rsp_valid, busy, sck, mosi, ncs;
  logic [7:0] rsp_data;
  assign ready     = sel ? b_ready     : a_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign busy      = sel ? b_busy      : a_busy;
  assign sck       = sel ? b_sck       : a_sck;
  assign mosi      = sel ? b_mosi      : a_mosi;
  assign ncs       = sel ? b_ncs       : a_ncs;

  typedef struct {
    logic [23:0] frame;
    logic [7:0]  rsp;
    int          ncs_len;
    int          period;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tgt_q[$];
  logic [7:0] tgt_cur = 8'h00;
  logic [23:0] tgt_frame;

  int vectors = 0, miscompares = 0;
  int cyc = 0, ncs_len = 0, high_run = 0, gap_run = 0;
  int nrise = 0, nfall = 0, last_rise = 0, per_min = 0, per_max = 0;
  int mosi_bad = 0, ready_bad = 0, busy_bad = 0, sck_bad = 0;
  int rsp_seen = 0, rsp_expected = 0;
  logic prev_sck = 1'b0, prev_ncs = 1'b1, mosi_at_rise = 1'b0;
  logic [23:0] rx = '0;

  // Target model: byte2 carries the register value, MSB first, advancing on SCK falls.
  assign tgt_frame = {16'h0000, tgt_cur};
  assign miso = (nfall < 24) ? tgt_frame[5'(23 - nfall)] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame tracking, line-protocol checks and scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    int   p;
    cyc++;
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid with data 0x%0h, none outstanding", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.rsp);
        chk("mosi_frame", rx, e.frame);
        chk("ncs_low_cycles", ncs_len, e.ncs_len);
        chk("sck_rises", nrise, 24);
        chk("sck_period_min", per_min, e.period);
        chk("sck_period_max", per_max, e.period);
      end
    end
    if (!ncs) begin
      if (prev_ncs) begin
        gap_run = high_run;
        ncs_len = 0; nrise = 0; nfall = 0; rx = '0;
        per_min = 1000; per_max = 0;
        if (tgt_q.size() != 0) tgt_cur = tgt_q.pop_front();
      end
      ncs_len++;
      high_run = 0;
      if (!busy) busy_bad++;
      if (!prev_sck && sck) begin
        if (nrise > 0) begin
          p = cyc - last_rise;
          if (p < per_min) per_min = p;
          if (p > per_max) per_max = p;
        end
        last_rise = cyc;
        nrise++;
        rx = {rx[22:0], mosi};
        mosi_at_rise = mosi;
      end else if (sck && (mosi !== mosi_at_rise)) begin
        mosi_bad++;
      end
      if (prev_sck && !sck) nfall++;
    end else begin
      high_run++;
      if (sck) sck_bad++;
    end
    if (busy && ready) ready_bad++;
    prev_sck = sck;
    prev_ncs = ncs;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic exp_t mk(input logic s, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] t);
    exp_t e;
    e.frame   = {(w ? 8'h80 : 8'h00), a, (w ? d : 8'h00)};
    e.rsp     = t;
    e.ncs_len = s ? NCS_B : NCS_A;
    e.period  = s ? PER_B : PER_A;
    return e;
  endfunction

  task automatic send(input logic s, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] t, input bit expect_rsp);
    sel = s;
    wait_ready();
    req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
    if (expect_rsp) begin
      exp_q.push_back(mk(s, w, a, d, t));
      rsp_expected++;
    end
    tgt_q.push_back(t);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ncs", ncs, 1);
    chk("rst_b_ncs", b_ncs, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);

    // Write 0x03 <= 0xA5; target still returns a byte which lands in rsp_data.
    send(1'b0, 1'b1, 8'h03, 8'hA5, 8'h3C, 1'b1);
    wait_drain();

    // Read 0x01; data byte on MOSI must be zero regardless of req_data.
    send(1'b0, 1'b0, 8'h01, 8'hEE, 8'h5C, 1'b1);
    wait_drain();

    // Two requests with req_valid held high; the second waits through GAP.
    sel = 1'b0;
    wait_ready();
    req_write = 1'b1; req_addr = 8'h10; req_data = 8'h11; req_valid = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 8'h10, 8'h11, 8'h22)); rsp_expected++;
    tgt_q.push_back(8'h22);
    @(posedge clk);
    #1;
    req_write = 1'b0; req_addr = 8'h20; req_data = 8'h77;
    exp_q.push_back(mk(1'b0, 1'b0, 8'h20, 8'h77, 8'hA7)); rsp_expected++;
    tgt_q.push_back(8'hA7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 5000);
    if (!ready) chk("b2b_ready_timeout", ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain();
    chk("b2b_ncs_high_gap", gap_run, 5);

    // Reset during bit 10 of a write: frame abandoned, no response.
    send(1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0);
    n = 0;
    while (nrise != 14 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit10", nrise, 14);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ncs", ncs, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 8'h00);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", ready, 1);

    // Following read completes normally.
    send(1'b0, 1'b0, 8'h02, 8'h00, 8'h96, 1'b1);
    wait_drain();

    // Fast instance: all-ones / all-zeros patterns.
    send(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b1);
    wait_drain();
    send(1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1);
    wait_drain();
    send(1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b1);
    wait_drain();

    repeat (20) @(negedge clk);
    chk("mosi_stable_while_sck_high", mosi_bad, 0);
    chk("ready_low_while_busy", ready_bad, 0);
    chk("busy_while_ncs_low", busy_bad, 0);
    chk("sck_low_while_deselected", sck_bad, 0);
    chk("rsp_pulse_count", rsp_seen, rsp_expected);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
